// File: rtl/clk_reset_sequencer_pkg.sv
// Shared types and default timing constants for the Ethernet clock/reset sequencer.
package eth_clk_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    GT_RST    = 3'd1,
    WAIT_GT   = 3'd2,
    PCS_WAIT  = 3'd3,
    MAC_WAIT  = 3'd4,
    READY     = 3'd5
  } seq_state_t;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned GT_RST_CYCLES_DEF  = 16;
  localparam int unsigned DONE_TIMEOUT_DEF   = 1024;
  localparam int unsigned PCS_RST_CYCLES_DEF = 8;
  localparam int unsigned MAC_RST_CYCLES_DEF = 8;
  localparam int unsigned CNT_W_DEF          = 11;

endpackage

// File: rtl/clk_reset_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by synchronous reset.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// Releases GT, PCS/PMA and MAC resets in order once the forwarded clock is locked,
// re-sequencing on lock loss, GT reset-done loss or GT reset-done timeout.
module clk_reset_sequencer
  import eth_clk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned GT_RST_CYCLES  = GT_RST_CYCLES_DEF,
  parameter int unsigned DONE_TIMEOUT   = DONE_TIMEOUT_DEF,
  parameter int unsigned PCS_RST_CYCLES = PCS_RST_CYCLES_DEF,
  parameter int unsigned MAC_RST_CYCLES = MAC_RST_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       gt_reset_done,
  output logic       gt_reset,
  output logic       pcs_reset,
  output logic       mac_reset,
  output logic       seq_ready,
  output logic [3:0] retry_count
);

  localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PCS_LAST  = CNT_W'(PCS_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MAC_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic lk_s;
  logic done_s;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             gt_reset_q, gt_reset_d;
  logic             pcs_reset_q, pcs_reset_d;
  logic             mac_reset_q, mac_reset_d;
  logic             seq_ready_q, seq_ready_d;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (lk_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
    .clk (clk),
    .rst (rst),
    .d   (gt_reset_done),
    .q   (done_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s) state_d = GT_RST;
      end
      GT_RST: begin
        if (cnt_q == GT_LAST) begin
          state_d = WAIT_GT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_GT: begin
        if (done_s) begin
          state_d = PCS_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == DONE_LAST) begin
          state_d = GT_RST;
          cnt_d   = '0;
          if (retry_q != 4'd15) retry_d = retry_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PCS_WAIT: begin
        if (!done_s) begin
          state_d = GT_RST;
          cnt_d   = '0;
        end else if (cnt_q == PCS_LAST) begin
          state_d = MAC_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      MAC_WAIT: begin
        if (!done_s) begin
          state_d = GT_RST;
          cnt_d   = '0;
        end else if (cnt_q == MAC_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      READY: begin
        cnt_d = '0;
        if (!done_s) state_d = GT_RST;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides everything, including a timeout retry in the same cycle.
    if ((state_q != WAIT_LOCK) && !lk_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      retry_d = retry_q;
    end

    gt_reset_d  = (state_d == WAIT_LOCK) || (state_d == GT_RST);
    pcs_reset_d = (state_d != MAC_WAIT) && (state_d != READY);
    mac_reset_d = (state_d != READY);
    seq_ready_d = (state_d == READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      retry_q     <= '0;
      gt_reset_q  <= 1'b1;
      pcs_reset_q <= 1'b1;
      mac_reset_q <= 1'b1;
      seq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      gt_reset_q  <= gt_reset_d;
      pcs_reset_q <= pcs_reset_d;
      mac_reset_q <= mac_reset_d;
      seq_ready_q <= seq_ready_d;
    end
  end

  assign gt_reset    = gt_reset_q;
  assign pcs_reset   = pcs_reset_q;
  assign mac_reset   = mac_reset_q;
  assign seq_ready   = seq_ready_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Directed bench for clk_reset_sequencer: edge counts of each reset release are
// compared against hand-derived cycle numbers for the default parameters.
module tb_clk_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       gtResetDone;
  logic       gtReset;
  logic       pcsReset;
  logic       macReset;
  logic       seqReady;
  logic [3:0] retryCount;

  int checkCount = 0;
  int errorCount = 0;
  bit orderOn    = 1'b0;
  int n;
  int bad;

  localparam int SEL_GT    = 0;
  localparam int SEL_PCS   = 1;
  localparam int SEL_MAC   = 2;
  localparam int SEL_READY = 3;
  localparam int LIMIT     = 2000;

  clk_reset_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .locked        (locked),
    .gt_reset_done (gtResetDone),
    .gt_reset      (gtReset),
    .pcs_reset     (pcsReset),
    .mac_reset     (macReset),
    .seq_ready     (seqReady),
    .retry_count   (retryCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic d);
    rst         = r;
    locked      = l;
    gtResetDone = d;
  endtask

  function automatic logic sigVal(input int sel);
    case (sel)
      SEL_GT:    return gtReset;
      SEL_PCS:   return pcsReset;
      SEL_MAC:   return macReset;
      default:   return seqReady;
    endcase
  endfunction

  // Counts clock edges until the selected output reaches val; gives up at limit.
  task automatic waitLevel(input int sel, input logic val, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while ((sigVal(sel) !== val) && (cycles < limit));
  endtask

  // Ordering invariant: mac released implies pcs released implies gt released.
  always @(negedge clk) begin
    if (orderOn)
      checkOutput("order", {30'd0, (!macReset && pcsReset), (!pcsReset && gtReset)}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values while rst is held.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    orderOn = 1'b1;
    checkOutput("rstGt", gtReset, 1);
    checkOutput("rstPcs", pcsReset, 1);
    checkOutput("rstMac", macReset, 1);
    checkOutput("rstReady", seqReady, 0);
    checkOutput("rstRetry", 32'(retryCount), 0);

    // Nominal: 2 sync edges + 1 to enter GT_RST + 16 in GT_RST = 19 edges to gt release.
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("postRstGt", gtReset, 1);
    checkOutput("postRstReady", seqReady, 0);
    waitLevel(SEL_GT, 1'b0, LIMIT, n);
    checkOutput("nomGtFall", n, 18);
    checkOutput("nomPcsHeld", pcsReset, 1);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1);
    // 2 sync edges + 1 to PCS_WAIT + 8 in PCS_WAIT.
    waitLevel(SEL_PCS, 1'b0, LIMIT, n);
    checkOutput("nomPcsFall", n, 11);
    checkOutput("nomMacHeld", macReset, 1);
    waitLevel(SEL_MAC, 1'b0, LIMIT, n);
    checkOutput("nomMacFall", n, 8);
    checkOutput("nomReady", seqReady, 1);
    checkOutput("nomRetry", 32'(retryCount), 0);

    // Late lock: everything held for 100 cycles with locked low.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!gtReset || !pcsReset || !macReset || seqReady) bad++;
    end
    checkOutput("lateHold", bad, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitLevel(SEL_GT, 1'b0, LIMIT, n);
    checkOutput("lateGtFall", n, 19);

    // Timeouts: 1024 cycles in WAIT_GT, 16 in GT_RST; retry saturates at 15.
    for (int k = 1; k <= 17; k++) begin
      waitLevel(SEL_GT, 1'b1, LIMIT, n);
      checkOutput($sformatf("toRise%0d", k), n, 1024);
      checkOutput($sformatf("toRetry%0d", k), 32'(retryCount), (k > 15) ? 15 : k);
      checkOutput($sformatf("toReady%0d", k), seqReady, 0);
      waitLevel(SEL_GT, 1'b0, LIMIT, n);
      checkOutput($sformatf("toFall%0d", k), n, 16);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitLevel(SEL_PCS, 1'b0, LIMIT, n);
    checkOutput("toPcsFall", n, 11);
    waitLevel(SEL_MAC, 1'b0, LIMIT, n);
    checkOutput("toMacFall", n, 8);
    checkOutput("toReadyEnd", seqReady, 1);
    checkOutput("toRetryEnd", 32'(retryCount), 15);

    // Lock loss in READY: lk_s low for one cycle, resets reassert on the 3rd edge.
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitLevel(SEL_GT, 1'b1, LIMIT, n);
    checkOutput("llGtRise", n, 2);
    checkOutput("llPcs", pcsReset, 1);
    checkOutput("llMac", macReset, 1);
    checkOutput("llReady", seqReady, 0);
    checkOutput("llRetry", 32'(retryCount), 15);
    waitLevel(SEL_GT, 1'b0, LIMIT, n);
    checkOutput("llGtFall", n, 17);
    waitLevel(SEL_PCS, 1'b0, LIMIT, n);
    checkOutput("llPcsFall", n, 9);
    waitLevel(SEL_MAC, 1'b0, LIMIT, n);
    checkOutput("llMacFall", n, 8);
    checkOutput("llReadyEnd", seqReady, 1);
    checkOutput("llRetryEnd", 32'(retryCount), 15);

    // gt_reset_done loss in READY forces a re-sequence from GT_RST.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitLevel(SEL_GT, 1'b1, LIMIT, n);
    checkOutput("dlGtRise", n, 3);
    checkOutput("dlMac", macReset, 1);
    checkOutput("dlReady", seqReady, 0);
    checkOutput("dlRetry", 32'(retryCount), 15);
    waitLevel(SEL_GT, 1'b0, LIMIT, n);
    checkOutput("dlGtFall", n, 16);

    // Mid-sequence reset while in PCS_WAIT.
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("msPcsHeld", pcsReset, 1);
    checkOutput("msGtLow", gtReset, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("msGt", gtReset, 1);
    checkOutput("msPcs", pcsReset, 1);
    checkOutput("msMac", macReset, 1);
    checkOutput("msReady", seqReady, 0);
    checkOutput("msRetry", 32'(retryCount), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitLevel(SEL_GT, 1'b0, LIMIT, n);
    checkOutput("msGtFall", n, 19);
    waitLevel(SEL_PCS, 1'b0, LIMIT, n);
    checkOutput("msPcsFall", n, 9);
    waitLevel(SEL_MAC, 1'b0, LIMIT, n);
    checkOutput("msMacFall", n, 8);
    checkOutput("msReadyEnd", seqReady, 1);

    orderOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
